param_accum_core: RTL and testbench
===================================

Name: param_accum_core

Overview:
- Parametrised, clocked successor to the team's 4-register accumulator processor.
- Executes one instruction word at a time over a valid/ready handshake. Holds a register file of NREG entries of DW bits; R0 is the accumulator.
- Supports move, store, load-immediate and a two-stage ALU operation that produces zero and carry flags.
- Sits between an instruction sequencer (upstream) and debug/observation logic (via acc_out, flags and the debug read port).

Parameters:
- DW, 8, data and register width (≥2).
- NREG, 4, register count; power of 2, ≥4. R0 is the accumulator; R[NREG-1] is the ALU backup register.
- RAW, $clog2(NREG), register address width (derived; do not override).
- IW, 4+2*RAW+DW, instruction width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instr holds a valid instruction.
- instr_ready  out  1  core can accept an instruction this cycle.
- instr  in  IW  instruction word: {imm[DW-1:0], rb[RAW-1:0], ra[RAW-1:0], alu_op[1:0], mode[1:0]}, mode in bits [1:0].
- done  out  1  one-cycle pulse when an instruction retires.
- acc_out  out  DW  current value of R0.
- flag_z  out  1  zero flag from the last ALU result.
- flag_c  out  1  carry/borrow flag from the last ALU result.
- dbg_sel  in  RAW  debug register select.
- dbg_data  out  DW  combinational read of R[dbg_sel].

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - all registers = 0, flag_z = 0, flag_c = 0, done = 0, state = IDLE.
  - instr_ready = 0 while in reset; it goes to 1 in the first cycle after deassertion.
- Accept: an instruction is accepted on a rising edge where instr_valid && instr_ready. instr need only be stable in the accept cycle.
- instr_ready = 1 only in IDLE.
- Modes:
  - 00 MOV: R0 <= R[ra]. Retires at the accept edge; done = 1 in the following cycle; stays in IDLE.
  - 01 STORE: R[ra] <= R0. ra=0 is a no-op that still retires. Same 1-cycle timing as MOV.
  - 10 LDI: R[ra] <= imm. Same 1-cycle timing as MOV.
  - 11 ALU: transition IDLE -> EXEC -> WB -> IDLE.
    - At the accept edge, latch opA = R0, opB = R[rb], and alu_op.
    - EXEC edge: R[NREG-1] <= opA (backup) and compute the result into a pipeline register.
    - WB edge: R0 <= result, update flag_z and flag_c. done = 1 in the cycle after the WB edge.
    - instr_ready is low in the EXEC and WB cycles, giving a throughput of one ALU instruction per 3 cycles.
- alu_op encoding:
  - 00 ADD: {c,res} = opA + opB, DW+1 bits wide.
  - 01 SUB: res = opA - opB mod 2^DW; c = 1 iff opA < opB (borrow).
  - 10 AND: c = 0.
  - 11 XOR: c = 0.
  - flag_z = (res == 0).
- Operands are latched at accept, so rb = NREG-1 reads the value held before the backup write. If rb = 0, opB = old R0.
- Flags are updated only by ALU instructions; MOV, STORE and LDI leave them unchanged.
- Because R0 is written at WB, the backup write to R[NREG-1] is overwritten by the result when NREG-1 = 0; this is impossible since NREG ≥ 4.
- instr_valid while busy: ignored (not accepted). The upstream must hold the instruction until instr_ready is high.
- Back-to-back: a new instruction can be accepted in the first IDLE cycle after WB, i.e. in the same cycle done is high. It sees the updated R0 and flags.
- Reset mid-ALU (in EXEC or WB): all state is cleared immediately, no partial writeback remains, and done does not pulse.
- dbg_data is combinational and reflects writes from the cycle after the write edge.

Decomposition:
- Shared package accum_pkg holds:
  - mode localparams MODE_MOV/MODE_STORE/MODE_LDI/MODE_ALU.
  - ALU op localparams OP_ADD/OP_SUB/OP_AND/OP_XOR.
  - the state enum IDLE/EXEC/WB.
  - instruction field offset constants.
- One natural sub-module, accum_alu: purely combinational, parametrised by DW; inputs opA, opB, op; outputs res, c, z.
- The FSM and register file stay in param_accum_core.

Test Plan:
All scenarios use DW=8, NREG=4.
- Reset: rst_n=0 for 3 cycles, then release → acc_out = 0, flags = 0, instr_ready = 1 on the first post-reset cycle, and dbg_data = 0 for every dbg_sel.
- LDI R1 = 0x2A, then STORE/MOV sequence (LDI R0 = 0x05, MOV R0 <- R1) → acc_out = 0x2A. Each instruction produces a done pulse 1 cycle after accept.
- ALU ADD: R0 = 0xF0, R2 = 0x20, ALU ADD rb = 2 → ready low 2 cycles, then acc_out = 0x10, flag_c = 1, flag_z = 0, R3 = 0xF0.
- ALU SUB with equal operands, then SUB borrow:
  - R0 = 0x33, R1 = 0x33, SUB rb = 1 → acc_out = 0x00, flag_z = 1, flag_c = 0.
  - Then LDI R1 = 0x01, SUB rb = 1 → acc_out = 0xFF, flag_c = 1.
- Busy and hazard:
  - Hold instr_valid high with an LDI during EXEC and WB → not accepted until IDLE, then accepted.
  - ALU XOR with rb = 3, where R3 = 0x0F and R0 = 0xFF → opB is the old R3, so acc_out = 0xF0 and R3 = 0xFF.
- Reset asserted in the EXEC cycle of an ADD → R0 = 0, no done pulse, instr_ready = 1 the cycle after release.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared constants for the parametrised accumulator core: instruction modes,
// ALU opcodes, FSM states and instruction field offsets.
package accum_pkg;

  localparam logic [1:0] MODE_MOV   = 2'b00;
  localparam logic [1:0] MODE_STORE = 2'b01;
  localparam logic [1:0] MODE_LDI   = 2'b10;
  localparam logic [1:0] MODE_ALU   = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  // instr = {imm, rb, ra, alu_op, mode}; only rb/imm depend on RAW
  localparam int MODE_LSB = 0;
  localparam int OP_LSB   = 2;
  localparam int RA_LSB   = 4;

  function automatic int rb_lsb(input int raw);
    return RA_LSB + raw;
  endfunction

  function automatic int imm_lsb(input int raw);
    return RA_LSB + 2 * raw;
  endfunction

endpackage

// File: rtl/accum_alu.sv
// Combinational ALU: ADD/SUB produce carry/borrow, logic ops clear carry.
module accum_alu
  import accum_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic [1:0]    op,
  output logic [DW-1:0] res,
  output logic          c,
  output logic          z
);

  logic [DW:0] wide;

  always_comb begin
    wide = '0;
    res  = '0;
    c    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, op_a} + {1'b0, op_b};
        res  = wide[DW-1:0];
        c    = wide[DW];
      end
      OP_SUB: begin
        // top bit of the widened difference is set exactly when op_a < op_b
        wide = {1'b0, op_a} - {1'b0, op_b};
        res  = wide[DW-1:0];
        c    = wide[DW];
      end
      OP_AND:  res = op_a & op_b;
      default: res = op_a ^ op_b;
    endcase
  end

  assign z = (res == '0);

endmodule

// File: rtl/param_accum_core.sv
// Accumulator core: register file, MOV/STORE/LDI in one cycle, ALU ops through
// an IDLE -> EXEC -> WB pipeline with backup of the old accumulator.
module param_accum_core
  import accum_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int RAW  = $clog2(NREG),
  parameter int IW   = 4 + 2 * RAW + DW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [IW-1:0]  instr,
  output logic           done,
  output logic [DW-1:0]  acc_out,
  output logic           flag_z,
  output logic           flag_c,
  input  logic [RAW-1:0] dbg_sel,
  output logic [DW-1:0]  dbg_data
);

  localparam int RB_LSB  = rb_lsb(RAW);
  localparam int IMM_LSB = imm_lsb(RAW);

  state_t state, state_nxt;

  logic [NREG-1:0][DW-1:0] regs;
  logic [DW-1:0]  op_a, op_b, res_q;
  logic [1:0]     op_q;
  logic           c_q, z_q;
  logic [DW-1:0]  alu_res;
  logic           alu_c, alu_z;

  logic [1:0]     mode, alu_op;
  logic [RAW-1:0] ra, rb;
  logic [DW-1:0]  imm;
  logic           accept;

  assign mode   = instr[MODE_LSB +: 2];
  assign alu_op = instr[OP_LSB +: 2];
  assign ra     = instr[RA_LSB +: RAW];
  assign rb     = instr[RB_LSB +: RAW];
  assign imm    = instr[IMM_LSB +: DW];

  // gated by rst_n so ready stays low throughout reset even though state is IDLE
  assign instr_ready = rst_n && (state == IDLE);
  assign accept      = instr_valid && instr_ready;

  assign acc_out  = regs[0];
  assign dbg_data = regs[dbg_sel];

  accum_alu #(.DW(DW)) u_alu (
    .op_a (op_a),
    .op_b (op_b),
    .op   (op_q),
    .res  (alu_res),
    .c    (alu_c),
    .z    (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && mode == MODE_ALU) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch and result pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      op_q  <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      if (accept && mode == MODE_ALU) begin
        op_a <= regs[0];
        op_b <= regs[rb];
        op_q <= alu_op;
      end
      if (state == EXEC) begin
        res_q <= alu_res;
        c_q   <= alu_c;
        z_q   <= alu_z;
      end
    end
  end

  // register file, flags and retire pulse; accept only happens in IDLE so
  // instruction writes never collide with the EXEC/WB writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs   <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (accept && mode != MODE_ALU) || (state == WB);
      if (accept) begin
        case (mode)
          MODE_MOV:   regs[0]  <= regs[ra];
          MODE_STORE: regs[ra] <= regs[0];
          MODE_LDI:   regs[ra] <= imm;
          default:    ;
        endcase
      end
      if (state == EXEC) regs[NREG-1] <= op_a;
      if (state == WB) begin
        regs[0] <= res_q;
        flag_z  <= z_q;
        flag_c  <= c_q;
      end
    end
  end

endmodule

// File: tb/tb_param_accum_core.sv
// Self-checking bench for param_accum_core (DW=8, NREG=4): directed vector
// table, busy/hazard and mid-ALU reset sequences, then random instructions.
module tb_param_accum_core;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int RAW  = 2;
  localparam int IW   = 4 + 2 * RAW + DW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           instr_valid;
  logic           instr_ready;
  logic [IW-1:0]  instr;
  logic           done;
  logic [DW-1:0]  acc_out;
  logic           flag_z, flag_c;
  logic [RAW-1:0] dbg_sel;
  logic [DW-1:0]  dbg_data;

  int errors = 0;
  int checks = 0;

  // reference state: plain arrays and arithmetic
  logic [7:0] m [NREG];
  logic       mz, mc;

  always #10 clk = ~clk;

  param_accum_core #(.DW(DW), .NREG(NREG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .done        (done),
    .acc_out     (acc_out),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  typedef struct {
    logic [1:0] mode, op, ra, rb;
    logic [7:0] imm, acc;
    logic       z, c;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m[i] = 8'h00;
    mz = 1'b0;
    mc = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] mode, op, ra, rb, input logic [7:0] imm);
    int a, b, r;
    case (mode)
      2'd0: m[0] = m[ra];
      2'd1: m[ra] = m[0];
      2'd2: m[ra] = imm;
      default: begin
        a = m[0];
        b = m[rb];
        case (op)
          2'd0: begin r = a + b; mc = (r > 255); end
          2'd1: begin r = a - b; mc = (a < b); if (r < 0) r += 256; end
          2'd2: begin r = a & b; mc = 1'b0; end
          default: begin r = a ^ b; mc = 1'b0; end
        endcase
        r = r % 256;
        mz = (r == 0);
        m[NREG-1] = a[7:0];
        m[0] = r[7:0];
      end
    endcase
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = i[RAW-1:0];
      #1;
      chk($sformatf("%s dbg R%0d", tag, i), dbg_data, m[i]);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge of
  // the done cycle, so a following call issues back-to-back.
  task automatic do_instr(input logic [1:0] mode, op, ra, rb, input logic [7:0] imm);
    int wait_cnt = 0;
    instr = {imm, rb, ra, op, mode};
    instr_valid = 1'b1;
    #1;
    while (!instr_ready && wait_cnt < 20) begin
      @(negedge clk); #1;
      wait_cnt++;
    end
    if (!instr_ready) begin
      chk("accept timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    if (mode == 2'd3) begin
      chk("alu exec ready", instr_ready, 1'b0);
      chk("alu exec done", done, 1'b0);
      @(negedge clk);
      chk("alu wb ready", instr_ready, 1'b0);
      chk("alu wb done", done, 1'b0);
      @(negedge clk);
    end
    chk("done pulse", done, 1'b1);
    chk("ready after retire", instr_ready, 1'b1);
    model_apply(mode, op, ra, rb, imm);
  endtask

  initial begin
    vt[0]  = '{2'd2, 2'd0, 2'd1, 2'd0, 8'h2A, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{2'd2, 2'd0, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 1'b0};
    vt[2]  = '{2'd0, 2'd0, 2'd1, 2'd0, 8'h00, 8'h2A, 1'b0, 1'b0};
    vt[3]  = '{2'd2, 2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b0, 1'b0};
    vt[4]  = '{2'd2, 2'd0, 2'd2, 2'd0, 8'h20, 8'hF0, 1'b0, 1'b0};
    vt[5]  = '{2'd3, 2'd0, 2'd0, 2'd2, 8'h00, 8'h10, 1'b0, 1'b1};
    vt[6]  = '{2'd2, 2'd0, 2'd0, 2'd0, 8'h33, 8'h33, 1'b0, 1'b1};
    vt[7]  = '{2'd2, 2'd0, 2'd1, 2'd0, 8'h33, 8'h33, 1'b0, 1'b1};
    vt[8]  = '{2'd3, 2'd1, 2'd0, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[9]  = '{2'd2, 2'd0, 2'd1, 2'd0, 8'h01, 8'h00, 1'b1, 1'b0};
    vt[10] = '{2'd3, 2'd1, 2'd0, 2'd1, 8'h00, 8'hFF, 1'b0, 1'b1};
    vt[11] = '{2'd1, 2'd0, 2'd2, 2'd0, 8'h00, 8'hFF, 1'b0, 1'b1};
    vt[12] = '{2'd2, 2'd0, 2'd3, 2'd0, 8'h0F, 8'hFF, 1'b0, 1'b1};
    vt[13] = '{2'd3, 2'd3, 2'd0, 2'd3, 8'h00, 8'hF0, 1'b0, 1'b0};

    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    dbg_sel = '0;
    model_reset();

    // reset held three cycles
    repeat (3) @(negedge clk);
    #1;
    chk("ready in reset", instr_ready, 1'b0);
    chk("done in reset", done, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("ready after reset", instr_ready, 1'b1);
    chk("acc after reset", acc_out, 8'h00);
    chk("flags after reset", {flag_z, flag_c}, 2'b00);
    check_regs("reset");

    // directed vector table
    for (int i = 0; i < 14; i++) begin
      do_instr(vt[i].mode, vt[i].op, vt[i].ra, vt[i].rb, vt[i].imm);
      chk($sformatf("vec%0d acc", i), acc_out, vt[i].acc);
      chk($sformatf("vec%0d z", i), flag_z, vt[i].z);
      chk($sformatf("vec%0d c", i), flag_c, vt[i].c);
      if (i == 5) begin
        dbg_sel = 2'd3; #1;
        chk("add backup R3", dbg_data, 8'hF0);
      end
      if (i == 13) begin
        dbg_sel = 2'd3; #1;
        chk("xor backup R3", dbg_data, 8'hFF);
      end
    end
    check_regs("table");

    // busy: an LDI held valid through EXEC/WB is only taken once IDLE again
    instr = {8'h00, 2'd1, 2'd0, 2'd0, 2'd3};
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr = {8'h77, 2'd0, 2'd1, 2'd0, 2'd2};
    #1;
    chk("busy exec ready", instr_ready, 1'b0);
    dbg_sel = 2'd1; #1;
    chk("busy exec R1", dbg_data, m[1]);
    @(negedge clk); #1;
    chk("busy wb ready", instr_ready, 1'b0);
    chk("busy wb R1", dbg_data, m[1]);
    @(negedge clk); #1;
    model_apply(2'd3, 2'd0, 2'd0, 2'd1, 8'h00);
    chk("busy alu done", done, 1'b1);
    chk("busy idle ready", instr_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    model_apply(2'd2, 2'd0, 2'd1, 2'd0, 8'h77);
    chk("held ldi done", done, 1'b1);
    dbg_sel = 2'd1; #1;
    chk("held ldi R1", dbg_data, 8'h77);
    chk("busy acc", acc_out, m[0]);
    @(negedge clk); #1;
    chk("done single cycle", done, 1'b0);

    // reset during EXEC of an ADD
    do_instr(2'd2, 2'd0, 2'd0, 2'd0, 8'h80);
    do_instr(2'd2, 2'd0, 2'd2, 2'd0, 8'h90);
    instr = {8'h00, 2'd2, 2'd0, 2'd0, 2'd3};
    instr_valid = 1'b1;
    #1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst acc", acc_out, 8'h00);
    chk("midrst ready", instr_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst release ready", instr_ready, 1'b1);
    chk("midrst done", done, 1'b0);
    @(negedge clk); #1;
    chk("midrst no done", done, 1'b0);
    chk("midrst flags", {flag_z, flag_c}, 2'b00);
    check_regs("midrst");

    // random instructions against the reference model
    for (int n = 0; n < 300; n++) begin
      do_instr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               8'($urandom));
      chk($sformatf("rnd%0d acc", n), acc_out, m[0]);
      chk($sformatf("rnd%0d flags", n), {flag_z, flag_c}, {mz, mc});
      if (n % 10 == 0) check_regs($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
